// File: rtl/if_pkg.sv
// ============================================================================
// if_pkg : shared types and constants for the instruction-fetch controller, rev 1.0
// ============================================================================
`default_nettype none

package if_pkg;

  localparam int PC_W = 32;

  typedef logic [1:0] state_t;
  localparam state_t BOOT       = 2'd0;
  localparam state_t FETCH      = 2'd1;
  localparam state_t WAIT_REDIR = 2'd2;

  localparam logic [PC_W-1:0] NOP_DEFAULT = 32'h0000_0000;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_OVR = 1'b1;

endpackage

`default_nettype wire

// File: rtl/if_ctr_wrap.sv
// ============================================================================
// if_ctr_wrap : wrapping up-counter with enable and synchronous clear, rev 1.0
// ============================================================================
`default_nettype none

module if_ctr_wrap #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
// ============================================================================
// if_fetch_ctrl : IF-stage sequencer; IF_PERF_CNT_EN adds perf counters, rev 1.0
// ============================================================================
`default_nettype none

module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [PC_W-1:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EX_MEM_PCSrc,
  input  logic [PC_W-1:0] EX_MEM_NPC,
  input  logic            stall_req,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic            pc_we,
  output logic            pc_sel,
  output logic [PC_W-1:0] override_pc,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic [PC_W-1:0] nop_instr,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_count,
`endif
  output logic [31:0]     fetch_count
);

  state_t          state_d, state_q;
  logic [PC_W-1:0] redir_pc_d, redir_pc_q;
  logic            fetch_inc;
`ifdef IF_PERF_CNT_EN
  logic            stall_inc;
  logic            flush_inc;
`endif

  assign nop_instr = NOP_INSTR;

  always_comb begin
    state_d     = state_q;
    redir_pc_d  = redir_pc_q;
    imem_req    = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_SEL_SEQ;
    override_pc = '0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    fetch_inc   = 1'b0;
`ifdef IF_PERF_CNT_EN
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
`endif
    if (rst_n) begin
      case (state_q)
        BOOT: begin
          pc_we       = 1'b1;
          pc_sel      = PC_SEL_OVR;
          override_pc = RESET_PC;
          ifid_we     = 1'b1;
          ifid_flush  = 1'b1;
          state_d     = FETCH;
        end
        FETCH: begin
          imem_req = 1'b1;
          // A redirect squashes whatever ID wanted to hold, so it beats stall_req.
          if (EX_MEM_PCSrc) begin
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            pc_sel      = PC_SEL_OVR;
            override_pc = EX_MEM_NPC;
            if (imem_ready) begin
              pc_we = 1'b1;
            end else begin
              redir_pc_d = EX_MEM_NPC;
              state_d    = WAIT_REDIR;
            end
          end else if (stall_req) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
          end else if (!imem_ready) begin
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
          end else begin
            pc_we     = 1'b1;
            ifid_we   = 1'b1;
            fetch_inc = 1'b1;
          end
        end
        WAIT_REDIR: begin
          imem_req    = 1'b1;
          ifid_we     = 1'b1;
          ifid_flush  = 1'b1;
          pc_sel      = PC_SEL_OVR;
          override_pc = redir_pc_q;
          if (EX_MEM_PCSrc) begin
            redir_pc_d  = EX_MEM_NPC;
            override_pc = EX_MEM_NPC;
          end
          if (imem_ready) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
`ifdef IF_PERF_CNT_EN
      stall_inc = (state_q == FETCH || state_q == WAIT_REDIR) && !pc_we;
      flush_inc = (state_q == FETCH || state_q == WAIT_REDIR) && EX_MEM_PCSrc;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  if_ctr_wrap #(.WIDTH(32)) u_fetch_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (fetch_inc),
    .count (fetch_count)
  );

`ifdef IF_PERF_CNT_EN
  if_ctr_wrap #(.WIDTH(32)) u_stall_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (stall_inc),
    .count (stall_cycles)
  );

  if_ctr_wrap #(.WIDTH(32)) u_flush_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (flush_inc),
    .count (flush_count)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
// ============================================================================
// tb_if_fetch_ctrl : directed self-checking bench for if_fetch_ctrl, rev 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        pcsrc;
  logic [31:0] npc;
  logic        stall_req;
  logic        imem_ready;
  logic        imem_req;
  logic        pc_we;
  logic        pc_sel;
  logic [31:0] override_pc;
  logic        ifid_we;
  logic        ifid_flush;
  logic [31:0] nop_instr;
  logic [31:0] fetch_count;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_ctrl #(
    .RESET_PC  (32'h0000_0100),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .EX_MEM_PCSrc (pcsrc),
    .EX_MEM_NPC   (npc),
    .stall_req    (stall_req),
    .imem_ready   (imem_ready),
    .imem_req     (imem_req),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .override_pc  (override_pc),
    .ifid_we      (ifid_we),
    .ifid_flush   (ifid_flush),
    .nop_instr    (nop_instr),
`ifdef IF_PERF_CNT_EN
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
`endif
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs for the next cycle are applied 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n      = 1'b0;
    pcsrc      = 1'b0;
    npc        = 32'h0;
    stall_req  = 1'b0;
    imem_ready = 1'b1;
    tick();
    tick();

    // Reset: outputs quiet except nop_instr
    settle();
    chk("rst_pc_we",     {31'd0, pc_we},      32'd0);
    chk("rst_imem_req",  {31'd0, imem_req},   32'd0);
    chk("rst_flush",     {31'd0, ifid_flush}, 32'd0);
    chk("rst_nop",       nop_instr,           32'h13);
    chk("rst_count",     fetch_count,         32'd0);

    // BOOT cycle
    rst_n = 1'b1;
    settle();
    chk("boot_ovr",      override_pc,         32'h100);
    chk("boot_pc_we",    {31'd0, pc_we},      32'd1);
    chk("boot_pc_sel",   {31'd0, pc_sel},     32'd1);
    chk("boot_flush",    {31'd0, ifid_flush}, 32'd1);
    chk("boot_imem_req", {31'd0, imem_req},   32'd0);
    tick();

    // Sequential fetch, counter 0,1,2 then 3
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("seq_pc_we",   {31'd0, pc_we},      32'd1);
      chk("seq_pc_sel",  {31'd0, pc_sel},     32'd0);
      chk("seq_flush",   {31'd0, ifid_flush}, 32'd0);
      chk("seq_count",   fetch_count,         k);
      tick();
    end
    settle();
    chk("seq_count3", fetch_count, 32'd3);

    // Stall for three cycles (memory not ready in the middle one)
    stall_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      imem_ready = (k != 1);
      settle();
      chk("stall_pc_we",   {31'd0, pc_we},   32'd0);
      chk("stall_ifid_we", {31'd0, ifid_we}, 32'd0);
      chk("stall_count",   fetch_count,      32'd3);
      tick();
    end
    stall_req  = 1'b0;
    imem_ready = 1'b1;
    settle();
    chk("resume_pc_we",   {31'd0, pc_we},   32'd1);
    chk("resume_ifid_we", {31'd0, ifid_we}, 32'd1);
    tick();
    settle();
    chk("resume_count",   fetch_count, 32'd4);

    // Redirect with memory ready
    pcsrc = 1'b1;
    npc   = 32'h40;
    settle();
    chk("redir_pc_sel", {31'd0, pc_sel},     32'd1);
    chk("redir_ovr",    override_pc,         32'h40);
    chk("redir_pc_we",  {31'd0, pc_we},      32'd1);
    chk("redir_flush",  {31'd0, ifid_flush}, 32'd1);
    tick();
    pcsrc = 1'b0;
    npc   = 32'h0;
    settle();
    chk("post_redir_sel",   {31'd0, pc_sel}, 32'd0);
    chk("post_redir_count", fetch_count,     32'd4);
    tick();

    // Bubble when memory is not ready
    imem_ready = 1'b0;
    settle();
    chk("bubble_pc_we", {31'd0, pc_we},      32'd0);
    chk("bubble_flush", {31'd0, ifid_flush}, 32'd1);
    chk("bubble_we",    {31'd0, ifid_we},    32'd1);
    tick();

    // Redirect while memory busy; ready returns two cycles later
    pcsrc = 1'b1;
    npc   = 32'h80;
    settle();
    chk("wr0_pc_we", {31'd0, pc_we},      32'd0);
    chk("wr0_flush", {31'd0, ifid_flush}, 32'd1);
    tick();
    pcsrc = 1'b0;
    npc   = 32'h0;
    settle();
    chk("wr1_pc_we", {31'd0, pc_we},      32'd0);
    chk("wr1_flush", {31'd0, ifid_flush}, 32'd1);
    chk("wr1_ovr",   override_pc,         32'h80);
    chk("wr1_req",   {31'd0, imem_req},   32'd1);
    tick();
    imem_ready = 1'b1;
    stall_req  = 1'b1;
    settle();
    chk("wr2_pc_we", {31'd0, pc_we},      32'd1);
    chk("wr2_ovr",   override_pc,         32'h80);
    chk("wr2_flush", {31'd0, ifid_flush}, 32'd1);
    tick();
    stall_req = 1'b0;
    settle();
    chk("wr_back_sel",   {31'd0, pc_sel}, 32'd0);
    chk("wr_back_count", fetch_count,     32'd5);
    tick();

    // Newest redirect wins inside WAIT_REDIR
    pcsrc      = 1'b1;
    npc        = 32'h80;
    imem_ready = 1'b0;
    tick();
    npc = 32'hC0;
    settle();
    chk("nw_ovr_now", override_pc,    32'hC0);
    chk("nw_pc_we0",  {31'd0, pc_we}, 32'd0);
    tick();
    pcsrc      = 1'b0;
    npc        = 32'h0;
    imem_ready = 1'b1;
    settle();
    chk("nw_ovr",    override_pc,    32'hC0);
    chk("nw_pc_we1", {31'd0, pc_we}, 32'd1);
    tick();
    settle();
    chk("nw_back_sel", {31'd0, pc_sel}, 32'd0);
    tick();

    // Stall and redirect together: redirect wins
    stall_req = 1'b1;
    pcsrc     = 1'b1;
    npc       = 32'h44;
    settle();
    chk("both_pc_we", {31'd0, pc_we},      32'd1);
    chk("both_flush", {31'd0, ifid_flush}, 32'd1);
    chk("both_ovr",   override_pc,         32'h44);
    chk("both_count", fetch_count,         32'd7);
    tick();

    // Reset during WAIT_REDIR drops the pending target
    stall_req  = 1'b0;
    npc        = 32'h200;
    imem_ready = 1'b0;
    tick();
    rst_n      = 1'b0;
    pcsrc      = 1'b0;
    npc        = 32'h0;
    imem_ready = 1'b1;
    settle();
    chk("rw_pc_we", {31'd0, pc_we},    32'd0);
    chk("rw_req",   {31'd0, imem_req}, 32'd0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("rw_boot_ovr",   override_pc,       32'h100);
    chk("rw_boot_pc_we", {31'd0, pc_we},    32'd1);
    chk("rw_boot_req",   {31'd0, imem_req}, 32'd0);
    chk("rw_count",      fetch_count,       32'd0);
    tick();
    settle();
    chk("rw_fetch_sel", {31'd0, pc_sel},     32'd0);
    chk("rw_fetch_we",  {31'd0, pc_we},      32'd1);
    chk("rw_fetch_fl",  {31'd0, ifid_flush}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Sequencer for the instruction-fetch stage. It generates PC write-enable, PC source select, IF/ID write-enable and IF/ID flush, and the instruction-memory request.
- Arbitrates between a taken branch/jump from EX/MEM, a load-use stall from ID, and a multi-cycle instruction memory (ready handshake).
- A redirect that arrives while memory is busy is held until the access completes.
- Sits beside the fetch datapath: PC register, PC-source mux, instruction memory, IF/ID register.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset.
NOP_INSTR, 32'h0000_0000, word the IF/ID register loads on flush (driven out on nop_instr).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
EX_MEM_PCSrc  in  1  taken branch/jump resolved in EX/MEM
EX_MEM_NPC  in  32  redirect target
stall_req  in  1  ID hazard unit requests fetch hold
imem_ready  in  1  instruction memory read data valid this cycle
imem_req  out  1  fetch access active
pc_we  out  1  PC register load enable
pc_sel  out  1  0 = incrementer output, 1 = override_pc
override_pc  out  32  non-sequential next PC
ifid_we  out  1  IF/ID register load enable
ifid_flush  out  1  IF/ID loads nop_instr instead of memory data
nop_instr  out  32  NOP_INSTR constant
fetch_count  out  32  instructions delivered to IF/ID

Behaviour:
General rules
- Outputs are combinational from state and inputs (Mealy). While rst_n=0, all outputs are 0 except nop_instr.
- On a clk edge with rst_n=0: state<=BOOT, redir_pc_q<=0, fetch_count<=0. Reset asserted mid-redirect drops the pending target.

States
- BOOT (one cycle):
  - pc_we=1, pc_sel=1, override_pc=RESET_PC
  - ifid_we=1, ifid_flush=1, imem_req=0
  - Next state: FETCH.
- FETCH: imem_req=1. Priority order:
  - EX_MEM_PCSrc=1 (stall_req ignored, since the stalled instruction is squashed). ifid_we=1, ifid_flush=1, override_pc=EX_MEM_NPC.
    - If imem_ready=1: pc_we=1, pc_sel=1; stay in FETCH.
    - Else: pc_we=0, redir_pc_q<=EX_MEM_NPC, go to WAIT_REDIR.
  - stall_req=1: pc_we=0, ifid_we=0 (IF/ID holds its value), regardless of imem_ready.
  - imem_ready=0: pc_we=0, ifid_we=1, ifid_flush=1 (bubble into ID).
  - Otherwise: pc_we=1, pc_sel=0, ifid_we=1, ifid_flush=0, fetch_count+1.
- WAIT_REDIR: the in-flight access to the old PC is discarded.
  - imem_req=1, ifid_we=1, ifid_flush=1 every cycle, pc_sel=1, override_pc=redir_pc_q.
  - A new EX_MEM_PCSrc=1 overwrites redir_pc_q (newest wins) and override_pc=EX_MEM_NPC that cycle.
  - When imem_ready=1: pc_we=1, go to FETCH.
  - stall_req is ignored in this state.

Counter and redirect latency
- fetch_count wraps 32'hFFFF_FFFF -> 0.
- Redirect latency: the target appears at the PC on the edge of the first imem_ready cycle at or after PCSrc.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs stall_cycles[31:0] (cycles with pc_we=0 in FETCH/WAIT_REDIR) and flush_count[31:0] (number of accepted redirects). Both reset to 0 and wrap.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package if_pkg:
  - state typedef (BOOT, FETCH, WAIT_REDIR)
  - PC_W=32
  - default NOP_INSTR constant
  - PC_SEL_SEQ=0, PC_SEL_OVR=1
- One natural sub-module: if_ctr_wrap, a parameterised wrapping counter with enable and synchronous clear. It is instanced for fetch_count and for the optional performance counters.

Test Plan:
- Reset, then imem_ready=1 held, RESET_PC=32'h100:
  - Reset release: BOOT cycle has override_pc=32'h100, pc_we=1, ifid_flush=1.
  - Following cycles have pc_we=1, pc_sel=0, and fetch_count increments 1,2,3.
- stall_req=1 for 3 cycles in FETCH -> pc_we=0 and ifid_we=0 for exactly 3 cycles; fetch_count unchanged; resumes on the 4th.
- EX_MEM_PCSrc=1, EX_MEM_NPC=32'h40, imem_ready=1 -> same cycle pc_sel=1, override_pc=32'h40, pc_we=1, ifid_flush=1; state stays FETCH.
- PCSrc with NPC=32'h80 while imem_ready=0, ready returns 2 cycles later:
  - WAIT_REDIR entered; flush asserted 3 cycles.
  - pc_we=1 with override_pc=32'h80 only on the ready cycle.
- In WAIT_REDIR, second PCSrc with NPC=32'hC0 before ready -> the PC loads 32'hC0, not 32'h80.
- Simultaneous stall_req=1 and PCSrc=1 -> redirect taken, ifid_flush=1, pc_we=1; stall ignored.
- rst_n=0 during WAIT_REDIR -> next state BOOT; the pending target is never loaded, and the PC loads RESET_PC.
